traffic_road_model: RTL

Behavioural-synthesisable model of the two roads at the intersection, sitting on the opposite side of the traffic light controller's interface. It consumes the light outputs LA/LB and produces the car-present sensor inputs TA/TB. Per-road car queues fill from arrival pulses and drain only while that road's light is green. A built-in protocol checker flags unsafe or out-of-order light behaviour. It closes the loop around the controller in block-level and system benches.

---
 rtl/traffic_road_model.sv | 130 +++++++++++++
 1 files changed

// File: rtl/traffic_road_model.sv
// traffic_road_model: closed-loop road model facing a traffic light controller.
// Ports: i_clk/i_rst (sync, active-high); i_arrive_a/b car arrivals;
//   i_LA/i_LB lights (00 G, 01 Y, 10 R, 11 illegal); o_TA/o_TB car present;
//   o_qcnt_a/b queue counts; o_depart_a/b departure pulses;
//   o_err_conflict/o_err_illegal/o_err_seq/o_overflow sticky flags.
module traffic_road_model #(
  parameter int QW          = 4,
  parameter int PASS_CYCLES = 2,
  parameter int MIN_YELLOW  = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_arrive_a,
  input  logic          i_arrive_b,
  input  logic [1:0]    i_LA,
  input  logic [1:0]    i_LB,
  output logic          o_TA,
  output logic          o_TB,
  output logic [QW-1:0] o_qcnt_a,
  output logic [QW-1:0] o_qcnt_b,
  output logic          o_depart_a,
  output logic          o_depart_b,
  output logic          o_err_conflict,
  output logic          o_err_illegal,
  output logic          o_err_seq,
  output logic          o_overflow
);

  localparam int PW = (PASS_CYCLES > 1) ? $clog2(PASS_CYCLES) : 1;
  localparam int YW = $clog2(MIN_YELLOW + 1);

  localparam logic [QW-1:0] QMAX  = '1;
  localparam logic [QW-1:0] Q_ONE = QW'(1);
  localparam logic [PW-1:0] PLAST = PW'(PASS_CYCLES - 1);
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [YW-1:0] YMIN  = YW'(MIN_YELLOW);
  localparam logic [YW-1:0] Y_ONE = YW'(1);

  localparam logic [1:0] GRN = 2'b00;
  localparam logic [1:0] YEL = 2'b01;
  localparam logic [1:0] RED = 2'b10;
  localparam logic [1:0] BAD = 2'b11;

  logic [1:0][1:0]    light;
  logic [1:0]         arrive;
  logic [1:0][QW-1:0] qcnt;
  logic [1:0][PW-1:0] ptmr;
  logic [1:0][YW-1:0] ycnt;
  logic [1:0][1:0]    prev;
  logic               primed;
  logic [1:0]         busy;
  logic [1:0]         depart;
  logic [1:0]         seq_bad;
  logic               conflict;
  logic               illegal;

  assign light  = {i_LB, i_LA};
  assign arrive = {i_arrive_b, i_arrive_a};

  always_comb begin
    busy     = '0;
    depart   = '0;
    seq_bad  = '0;
    conflict = (i_LA != RED) && (i_LB != RED);
    illegal  = (i_LA == BAD) || (i_LB == BAD);
    for (int i = 0; i < 2; i++) begin
      busy[i]   = (light[i] == GRN) && (qcnt[i] != '0);
      depart[i] = !i_rst && busy[i] && (ptmr[i] == PLAST);
      // Transitions touching 2'b11 are reported only as illegal.
      if (primed && (light[i] != prev[i]) &&
          (light[i] != BAD) && (prev[i] != BAD)) begin
        seq_bad[i] = !(
          ((prev[i] == GRN) && (light[i] == YEL)) ||
          ((prev[i] == YEL) && (light[i] == RED) &&
           (ycnt[i] >= YMIN)) ||
          ((prev[i] == RED) && (light[i] == GRN)));
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      qcnt           <= '0;
      ptmr           <= '0;
      ycnt           <= '0;
      prev           <= '0;
      primed         <= 1'b0;
      o_err_conflict <= 1'b0;
      o_err_illegal  <= 1'b0;
      o_err_seq      <= 1'b0;
      o_overflow     <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        // Leaving green or emptying the queue abandons a partial pass.
        if (!busy[i] || (ptmr[i] == PLAST))
          ptmr[i] <= '0;
        else
          ptmr[i] <= ptmr[i] + P_ONE;

        if (arrive[i] && !depart[i]) begin
          if (qcnt[i] == QMAX)
            o_overflow <= 1'b1;
          else
            qcnt[i] <= qcnt[i] + Q_ONE;
        end else if (!arrive[i] && depart[i]) begin
          qcnt[i] <= qcnt[i] - Q_ONE;
        end

        if (light[i] != YEL)
          ycnt[i] <= '0;
        else if (ycnt[i] != YMIN)
          ycnt[i] <= ycnt[i] + Y_ONE;

        prev[i] <= light[i];
      end
      primed <= 1'b1;
      if (conflict)   o_err_conflict <= 1'b1;
      if (illegal)    o_err_illegal  <= 1'b1;
      if (|seq_bad)   o_err_seq      <= 1'b1;
    end
  end

  assign o_qcnt_a   = qcnt[0];
  assign o_qcnt_b   = qcnt[1];
  assign o_TA       = (qcnt[0] != '0);
  assign o_TB       = (qcnt[1] != '0);
  assign o_depart_a = depart[0];
  assign o_depart_b = depart[1];

endmodule
